// File: rtl/dmem_if.sv
// dmem_if: load/store request and response channels between CPU and data memory
// master: drives req_valid, req_wr, req_addr, req_wdata, resp_ready
// slave: drives req_ready, resp_valid, resp_rdata, resp_err
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic        resp_err;
   modport master (
      output req_valid, req_wr, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder with fixed access latency
// clk, rst   : clock and synchronous active-high reset
// bus        : dmem_if slave (request accepted in IDLE, response held until taken)
// busy       : high while a request is in flight or its response is pending
module dmem_responder #(
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 15
) (
   input  logic   clk,
   input  logic   rst,
   dmem_if.slave  bus,
   output logic   busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t            state, state_n;
   logic [3:0]        cnt;
   logic              wr, err, rerr, commit;
   logic [ADDR_W-1:0] idx;
   logic [15:0]       wdata, rdata;
   logic [15:0]       mem [2**ADDR_W];
   // the WAIT->RESP edge is the single point where the access takes effect
   assign commit         = state == WAIT && cnt == 4'd0;
   assign bus.req_ready  = state == IDLE;
   assign bus.resp_valid = state == RESP;
   assign bus.resp_rdata = rdata;
   assign bus.resp_err   = rerr;
   assign busy           = state != IDLE;
   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (bus.req_valid ? WAIT : IDLE) :
                state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
                                (bus.resp_ready ? IDLE : RESP);
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= 4'd0;
         rdata <= 16'h0000;
         rerr  <= 1'b0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            wr    <= bus.req_wr;
            idx   <= bus.req_addr[ADDR_W:1];
            wdata <= bus.req_wdata;
            err   <= bus.req_addr[0];
            cnt   <= 4'(LATENCY - 1);
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (commit) begin
            rdata <= wr ? 16'h0000 : mem[idx];
            rerr  <= err;
         end else if (state == RESP && bus.resp_ready) begin
            rdata <= 16'h0000;
            rerr  <= 1'b0;
         end
      end
   end
   // array is never reset; a reset on the commit edge suppresses the write
   always_ff @(posedge clk) begin
      if (!rst && commit && wr) mem[idx] <= wdata;
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (LATENCY 4 and 1)
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_busy, b_busy;
   int   total = 0;
   int   bad = 0;
   dmem_if a();
   dmem_if b();
   dmem_responder #(.LATENCY(4), .ADDR_W(15)) dut_a (.clk(clk), .rst(rst), .bus(a.slave), .busy(a_busy));
   dmem_responder #(.LATENCY(1), .ADDR_W(15)) dut_b (.clk(clk), .rst(rst), .bus(b.slave), .busy(b_busy));
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic issue_a(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
      a.req_valid = 1'b1;
      a.req_wr    = wr;
      a.req_addr  = addr;
      a.req_wdata = wdata;
      tick;
      a.req_valid = 1'b0;
   endtask
   task automatic wait_a(input string tag, input int exp_n);
      int n = 0;
      while (!a.resp_valid && n < 20) begin
         tick;
         n++;
      end
      chk({tag, "_lat"}, n, exp_n);
   endtask
   task automatic finish_a(input string tag);
      a.resp_ready = 1'b1;
      tick;
      chk({tag, "_rdy"}, a.req_ready, 1);
      chk({tag, "_vld"}, a.resp_valid, 0);
      chk({tag, "_clr"}, {a.resp_err, a.resp_rdata}, 0);
   endtask
   initial begin
      a.req_valid = 0; a.req_wr = 0; a.req_addr = 0; a.req_wdata = 0; a.resp_ready = 1;
      b.req_valid = 0; b.req_wr = 0; b.req_addr = 0; b.req_wdata = 0; b.resp_ready = 1;
      tick;
      tick;
      rst = 1'b0;
      chk("rst_rdy", a.req_ready, 1);
      chk("rst_vld", a.resp_valid, 0);
      chk("rst_data", {a.resp_err, a.resp_rdata}, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_b", {b.req_ready, b.resp_valid, b_busy}, 3'b100);
      issue_a(1'b1, 16'h0010, 16'hBEEF);
      chk("st_rdy_drop", a.req_ready, 0);
      chk("st_busy", a_busy, 1);
      repeat (3) tick;
      chk("st_early", a.resp_valid, 0);
      tick;
      chk("st_vld", a.resp_valid, 1);
      chk("st_rdata", a.resp_rdata, 16'h0000);
      chk("st_err", a.resp_err, 0);
      tick;
      chk("st_rdy_back", a.req_ready, 1);
      chk("st_vld_clr", a.resp_valid, 0);
      issue_a(1'b0, 16'h0010, 16'h0000);
      wait_a("ld10", 4);
      chk("ld10_data", a.resp_rdata, 16'hBEEF);
      chk("ld10_err", a.resp_err, 0);
      finish_a("ld10");
      issue_a(1'b0, 16'h0011, 16'h0000);
      wait_a("ld11", 4);
      chk("ld11_data", a.resp_rdata, 16'hBEEF);
      chk("ld11_err", a.resp_err, 1);
      finish_a("ld11");
      a.resp_ready = 1'b0;
      issue_a(1'b0, 16'h0010, 16'h0000);
      wait_a("bp", 4);
      for (int i = 0; i < 6; i++) begin
         tick;
         chk("bp_hold_vld", a.resp_valid, 1);
         chk("bp_hold_data", a.resp_rdata, 16'hBEEF);
         chk("bp_hold_rdy", a.req_ready, 0);
      end
      finish_a("bp");
      issue_a(1'b1, 16'h0020, 16'h5A5A);
      wait_a("pre20", 4);
      finish_a("pre20");
      issue_a(1'b1, 16'h0020, 16'h1234);
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rw_rdy", a.req_ready, 1);
      chk("rw_vld", a.resp_valid, 0);
      chk("rw_busy", a_busy, 0);
      chk("rw_data", {a.resp_err, a.resp_rdata}, 0);
      issue_a(1'b0, 16'h0020, 16'h0000);
      wait_a("rw_ld", 4);
      chk("rw_ld_data", a.resp_rdata, 16'h5A5A);
      finish_a("rw_ld");
      a.resp_ready = 1'b0;
      issue_a(1'b1, 16'h0020, 16'h1234);
      wait_a("rr", 4);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("rr_vld", a.resp_valid, 0);
      chk("rr_rdy", a.req_ready, 1);
      chk("rr_busy", a_busy, 0);
      a.resp_ready = 1'b1;
      issue_a(1'b0, 16'h0020, 16'h0000);
      wait_a("rr_ld", 4);
      chk("rr_ld_data", a.resp_rdata, 16'h1234);
      finish_a("rr_ld");
      a.req_valid = 1'b1; a.req_wr = 1'b0; a.req_addr = 16'h0010;
      tick;
      a.req_wr = 1'b1; a.req_addr = 16'h0021; a.req_wdata = 16'hDEAD;
      tick;
      a.req_valid = 1'b0;
      chk("ign_rdy", a.req_ready, 0);
      wait_a("ign", 3);
      chk("ign_data", a.resp_rdata, 16'hBEEF);
      chk("ign_err", a.resp_err, 0);
      finish_a("ign");
      chk("ign_idle", a_busy, 0);
      issue_a(1'b0, 16'h0020, 16'h0000);
      wait_a("ign_ld", 4);
      chk("ign_ld_data", a.resp_rdata, 16'h1234);
      finish_a("ign_ld");
      b.req_valid = 1'b1; b.req_wr = 1'b1; b.req_addr = 16'h0002; b.req_wdata = 16'hCAFE;
      tick;
      chk("l1_st_acc", {b.req_ready, b_busy}, 2'b01);
      b.req_wr = 1'b0;
      tick;
      chk("l1_st_vld", b.resp_valid, 1);
      chk("l1_st_data", b.resp_rdata, 16'h0000);
      tick;
      chk("l1_st_done", {b.req_ready, b.resp_valid}, 2'b10);
      tick;
      chk("l1_ld_acc", {b.req_ready, b_busy}, 2'b01);
      tick;
      chk("l1_ld_vld", b.resp_valid, 1);
      chk("l1_ld_data", b.resp_rdata, 16'hCAFE);
      b.req_valid = 1'b0;
      tick;
      chk("l1_ld_done", {b.req_ready, b.resp_valid, b_busy}, 3'b100);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
